// File: rtl/polynomial_pkg.sv
// Shared constants and types for the cubic-polynomial coefficient path.
// Coefficients are fixed-point 24:8; words are always streamed in a, b, c, d order.
package polynomial_pkg;

  localparam int W         = 32;
  localparam int FXP_SHIFT = 8;

  typedef enum logic [1:0] {
    COEF_A = 2'd0,
    COEF_B = 2'd1,
    COEF_C = 2'd2,
    COEF_D = 2'd3
  } coef_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/polynomial_coef_bank.sv
// NUM_POLY x 4 x W coefficient register file: one write port, one combinational read port.
// Reset clears every entry; out-of-range writes are ignored.
module polynomial_coef_bank #(
  parameter  int W        = 32,
  parameter  int NUM_POLY = 4,
  localparam int PW       = $clog2(NUM_POLY)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_poly,
  input  logic [1:0]    wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic [PW-1:0] rd_poly,
  input  logic [1:0]    rd_idx,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [NUM_POLY][4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_POLY; p++) begin
        for (int i = 0; i < 4; i++) begin
          mem[p][i] <= '0;
        end
      end
    end else if (wr_en && (int'(wr_poly) < NUM_POLY)) begin
      mem[wr_poly][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_poly][rd_idx];

endmodule

// File: rtl/polynomial_coef_loader.sv
// Streams one stored coefficient set (a,b,c,d) to the evaluator after a coef_reset pulse.
// Load takes 6 cycles with coef_ready high; coef/coef_valid hold while coef_ready is low.
module polynomial_coef_loader #(
  parameter  int W        = 32,
  parameter  int NUM_POLY = 4,
  localparam int PW       = $clog2(NUM_POLY)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_poly,
  input  logic [1:0]    wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          load_req,
  input  logic [PW-1:0] load_poly,
  output logic          busy,
  output logic          load_done,
  output logic          load_err,
  output logic          wr_err,
  output logic [W-1:0]  coef,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic          coef_last,
  output logic          coef_reset
);

  import polynomial_pkg::*;

  load_state_t   state;
  logic [1:0]    cnt;
  logic [PW-1:0] sel_poly;
  logic [1:0]    rd_idx;
  logic [W-1:0]  rd_data;
  logic          wr_ok;
  logic          load_ok;
  logic          bank_we;
  logic          xfer;

  // The set being streamed is write-protected so the evaluator never sees a mixed set.
  always_comb begin
    wr_ok   = (int'(wr_poly) < NUM_POLY) &&
              !((state != IDLE) && (wr_poly == sel_poly));
    load_ok = (state == IDLE) && (int'(load_poly) < NUM_POLY);
    bank_we = wr_en && wr_ok;
    xfer    = (state == SEND) && coef_valid && coef_ready;
    rd_idx  = (state == SEND) ? cnt + 2'd1 : COEF_A;
  end

  polynomial_coef_bank #(
    .W        (W),
    .NUM_POLY (NUM_POLY)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bank_we),
    .wr_poly (wr_poly),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_poly (sel_poly),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_poly   <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      wr_err     <= 1'b0;
      coef       <= '0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
      coef_reset <= 1'b0;
    end else begin
      coef_reset <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= load_req && !load_ok;
      wr_err     <= wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (load_req && load_ok) begin
            sel_poly   <= load_poly;
            state      <= CLEAR;
            coef_reset <= 1'b1;
            busy       <= 1'b1;
          end
        end
        CLEAR: begin
          state      <= SEND;
          cnt        <= COEF_A;
          coef       <= rd_data;
          coef_valid <= 1'b1;
          coef_last  <= 1'b0;
        end
        SEND: begin
          // The read port already points at the next word, so it is ready to register.
          if (xfer) begin
            if (cnt == COEF_D) begin
              state      <= DONE;
              cnt        <= '0;
              coef_valid <= 1'b0;
              coef_last  <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              cnt       <= cnt + 2'd1;
              coef      <= rd_data;
              coef_last <= (cnt == COEF_C);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polynomial_coef_loader.sv
// Directed plus randomized bench for polynomial_coef_loader, checked against a bank/stream model.
module tb_polynomial_coef_loader;

  localparam int NP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_poly = '0;
  logic [1:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic        load_req = 1'b0;
  logic [1:0]  load_poly = '0;
  logic        coef_ready = 1'b0;

  logic        busy, load_done, load_err, wr_err, coef_valid, coef_last, coef_reset;
  logic [31:0] coef;
  logic        busy3, load_done3, load_err3, wr_err3, coef_valid3, coef_last3, coef_reset3;
  logic [31:0] coef3;

  logic [31:0] ref_bank [NP][4];
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  polynomial_coef_loader #(.W(32), .NUM_POLY(4)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_poly(wr_poly), .wr_idx(wr_idx),
    .wr_data(wr_data), .load_req(load_req), .load_poly(load_poly), .busy(busy),
    .load_done(load_done), .load_err(load_err), .wr_err(wr_err), .coef(coef),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_last(coef_last),
    .coef_reset(coef_reset)
  );

  // Three-deep instance: index 3 is out of range, exercising the non-power-of-2 rejections.
  polynomial_coef_loader #(.W(32), .NUM_POLY(3)) dut3 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_poly(wr_poly), .wr_idx(wr_idx),
    .wr_data(wr_data), .load_req(load_req), .load_poly(load_poly), .busy(busy3),
    .load_done(load_done3), .load_err(load_err3), .wr_err(wr_err3), .coef(coef3),
    .coef_valid(coef_valid3), .coef_ready(coef_ready), .coef_last(coef_last3),
    .coef_reset(coef_reset3)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      2:       return !(c == 3 || c == 4);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic wr(input int p, input int i, input logic [31:0] d);
    wr_en = 1'b1; wr_poly = 2'(p); wr_idx = 2'(i); wr_data = d;
    step();
    wr_en = 1'b0;
    chk("wr_err_idle", wr_err, 0);
    ref_bank[p][i] = d;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low in cycles 3-4.
  task automatic do_load(input int p, input int mode, input bit inj, input bit sim_wr,
                         input string tag);
    logic [31:0] exp_w [4];
    logic [31:0] rnd;
    int k;
    int c;
    logic go;
    logic moved;
    if (sim_wr) begin
      wr_en = 1'b1; wr_poly = 2'(p); wr_idx = 2'd0; wr_data = 32'h1234;
      ref_bank[p][0] = 32'h1234;
    end
    for (int i = 0; i < 4; i++) exp_w[i] = ref_bank[p][i];
    load_req = 1'b1; load_poly = 2'(p); coef_ready = rdy(mode, 0);
    step();
    load_req = 1'b0; wr_en = 1'b0;
    if (sim_wr) begin
      chk({tag, "_wr_err"}, wr_err, 0);
      chk({tag, "_np3_wr_err"}, wr_err3, 1);
      chk({tag, "_np3_load_err"}, load_err3, 1);
      chk({tag, "_np3_busy"}, busy3, 0);
      chk({tag, "_np3_coef_reset"}, coef_reset3, 0);
      chk({tag, "_np3_valid"}, coef_valid3, 0);
      chk({tag, "_np3_last"}, coef_last3, 0);
      chk({tag, "_np3_done"}, load_done3, 0);
    end
    c = 1; k = 0;
    while (k < 4 && c < 200) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_coef_reset"}, coef_reset, (c == 1));
      chk({tag, "_done_early"}, load_done, 0);
      if (!(inj && c == 4)) begin
        chk({tag, "_load_err"}, load_err, 0);
        chk({tag, "_wr_err"}, wr_err, 0);
      end
      if (c >= 2) begin
        chk({tag, "_valid"}, coef_valid, 1);
        chk({tag, "_coef"}, coef, exp_w[k]);
        chk({tag, "_last"}, coef_last, (k == 3));
      end else begin
        chk({tag, "_valid_clear"}, coef_valid, 0);
      end
      if (inj && c == 3) begin
        load_req = 1'b1; load_poly = 2'd2;
        wr_en = 1'b1; wr_poly = 2'(p); wr_idx = 2'd3; wr_data = 32'hFFFF;
      end
      if (inj && c == 4) begin
        chk({tag, "_busy_load_err"}, load_err, 1);
        chk({tag, "_hazard_wr_err"}, wr_err, 1);
        rnd = $urandom;
        load_req = 1'b0;
        wr_poly = 2'd0; wr_idx = 2'd2; wr_data = rnd;
        ref_bank[0][2] = rnd;
      end
      if (inj && c == 5) wr_en = 1'b0;
      go = rdy(mode, c);
      coef_ready = go;
      moved = coef_valid && go;
      step();
      c++;
      if (moved) k++;
    end
    chk({tag, "_xfers"}, k, 4);
    chk({tag, "_load_done"}, load_done, 1);
    chk({tag, "_valid_drop"}, coef_valid, 0);
    chk({tag, "_busy_done"}, busy, 1);
    if (mode == 0) chk({tag, "_done_cycle"}, c, 6);
    if (mode == 2) chk({tag, "_done_cycle"}, c, 8);
    step();
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_done_pulse"}, load_done, 0);
  endtask

  initial begin
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 4; i++) ref_bank[p][i] = '0;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", coef_valid, 0);
    chk("rst_coef", coef, 0);
    chk("rst_done", load_done, 0);
    chk("rst_coef_reset", coef_reset, 0);
    chk("rst_last", coef_last, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_wr_err", wr_err, 0);
    step(); step();
    reset = 1'b0;
    step();

    wr(1, 0, 32'h100); wr(1, 1, 32'h200); wr(1, 2, 32'h300); wr(1, 3, 32'h400);
    do_load(1, 0, 1'b0, 1'b0, "basic");
    do_load(1, 2, 1'b0, 1'b0, "backpressure");
    do_load(1, 0, 1'b1, 1'b0, "hazard");
    chk("hazard_model_d", ref_bank[1][3], 32'h400);
    do_load(0, 0, 1'b0, 1'b0, "poly0_after");

    // Abort a stream just after the b word has transferred.
    load_req = 1'b1; load_poly = 2'd1; coef_ready = 1'b1;
    step();
    load_req = 1'b0;
    step(); step(); step();
    chk("midrst_pre_coef", coef, ref_bank[1][2]);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", coef_valid, 0);
    chk("midrst_coef", coef, 0);
    chk("midrst_last", coef_last, 0);
    chk("midrst_coef_reset", coef_reset, 0);
    chk("midrst_done", load_done, 0);
    step();
    chk("midrst_done_hold", load_done, 0);
    reset = 1'b0;
    step();
    chk("midrst_done_after", load_done, 0);
    chk("midrst_busy_after", busy, 0);
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 4; i++) ref_bank[p][i] = '0;
    do_load(1, 0, 1'b0, 1'b0, "post_reset");

    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < 4; j++) wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      do_load(int'($urandom_range(0, 3)), 1, 1'b0, 1'b0, "random");
    end

    do_load(3, 0, 1'b0, 1'b1, "same_cycle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
